// File: rtl/not_gate_rr_arbiter.sv
// ============================================================================
// Module      : not_gate_rr_arbiter
// Description : Round-robin arbiter sharing one WIDTH-bit inverter among
//               N_REQ requesters, with a registered single-entry output stage.
//               Optional macro NOT_GATE_ARB_GRANT_CNT_EN adds a 16-bit
//               transfer counter port (grant_cnt).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module not_gate_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [ID_W-1:0]        out_id,
    input  logic                   out_ready
`ifdef NOT_GATE_ARB_GRANT_CNT_EN
    ,
    output logic [15:0]            grant_cnt
`endif
);

    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N_REQ - 1);

    logic [ID_W-1:0]  ptr;
    logic [N_REQ-1:0] gnt;
    logic             found;
    logic [ID_W-1:0]  win_idx;
    logic [WIDTH-1:0] win_data;
    logic             can_accept;
    logic             xfer;

    // Search starts at ptr and wraps; the first valid requester wins.
    always_comb begin
        gnt      = '0;
        found    = 1'b0;
        win_idx  = '0;
        win_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req_valid[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                win_idx  = ID_W'(idx);
                win_data = req_data[idx*WIDTH +: WIDTH];
            end
        end
    end

    assign can_accept = !out_valid || out_ready;
    assign xfer       = rst_n && found && can_accept;

    // Gating with rst_n keeps all ready bits low while reset is held.
    generate
        for (genvar g = 0; g < N_REQ; g++) begin : g_ready
            assign req_ready[g] = rst_n & can_accept & gnt[g];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= ~win_data;
            out_id    <= win_idx;
            ptr       <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef NOT_GATE_ARB_GRANT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= 16'h0000;
        end else if (xfer) begin
            grant_cnt <= grant_cnt + 16'h0001;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_not_gate_rr_arbiter.sv
// ============================================================================
// Module      : tb_not_gate_rr_arbiter
// Description : Directed self-checking bench for not_gate_rr_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_not_gate_rr_arbiter;

    localparam int N_REQ = 4;
    localparam int WIDTH = 8;
    localparam int ID_W  = 2;

    logic                   clk;
    logic                   rst_n;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_ready;
    logic                   out_valid;
    logic [WIDTH-1:0]       out_data;
    logic [ID_W-1:0]        out_id;
    logic                   out_ready;
`ifdef NOT_GATE_ARB_GRANT_CNT_EN
    logic [15:0]            grant_cnt;
`endif

    int n_cmp;
    int n_err;

    not_gate_rr_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready)
`ifdef NOT_GATE_ARB_GRANT_CNT_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_data  = '0;
        out_ready = 1'b1;
        step();
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h expected 00", out_data); end
        n_cmp++; if (out_id !== 2'd0) begin n_err++; $display("FAIL reset_id: got %0d expected 0", out_id); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL first_grant: got %b expected 0001", req_ready); end
        step();
        req_valid = 4'b0000;
        n_cmp++; if (out_valid !== 1'b1 || out_id !== 2'd0 || out_data !== 8'hFF) begin n_err++; $display("FAIL first_result: got v=%b id=%0d d=%h expected v=1 id=0 d=ff", out_valid, out_id, out_data); end
        step();
        n_cmp++; if (out_valid !== 1'b0 || out_data !== 8'hFF) begin n_err++; $display("FAIL drain: got v=%b d=%h expected v=0 d=ff", out_valid, out_data); end
    endtask

    // ptr is 1 here, so search 1 -> 2 finds requester 2.
    task automatic test_single();
        req_valid = 4'b0100;
        req_data  = 32'h00_A5_00_00;
        out_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
        step();
        req_valid = 4'b0000;
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h5A || out_id !== 2'd2) begin n_err++; $display("FAIL single_result: got v=%b id=%0d d=%h expected v=1 id=2 d=5a", out_valid, out_id, out_data); end
        step();
        n_cmp++; if (out_valid !== 1'b0 || out_data !== 8'h5A || out_id !== 2'd2) begin n_err++; $display("FAIL single_hold: got v=%b id=%0d d=%h expected v=0 id=2 d=5a", out_valid, out_id, out_data); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_id [5];
        logic [7:0] exp_d  [5];
        exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_d  = '{8'hFF, 8'hF0, 8'h0F, 8'h00, 8'hFF};
        rst_n = 1'b0;
        #1;
        rst_n     = 1'b1;
        req_valid = 4'b1111;
        req_data  = 32'hFF_F0_0F_00;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            n_cmp++;
            if (out_valid !== 1'b1 || out_id !== exp_id[k] || out_data !== exp_d[k]) begin
                n_err++;
                $display("FAIL rr_%0d: got v=%b id=%0d d=%h expected v=1 id=%0d d=%h", k, out_valid, out_id, out_data, exp_id[k], exp_d[k]);
            end
        end
    endtask

    // Entry state: result id0/ff held, ptr=1, all requesters valid.
    task automatic test_backpressure();
        out_ready = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_ready_now: got %b expected 0000", req_ready); end
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++;
            if (out_valid !== 1'b1 || out_id !== 2'd0 || out_data !== 8'hFF || req_ready !== 4'b0000) begin
                n_err++;
                $display("FAIL bp_hold_%0d: got v=%b id=%0d d=%h rdy=%b expected v=1 id=0 d=ff rdy=0000", k, out_valid, out_id, out_data, req_ready);
            end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_ptr: got %b expected 0010", req_ready); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_id !== 2'd1 || out_data !== 8'hF0) begin n_err++; $display("FAIL bp_drain_xfer: got v=%b id=%0d d=%h expected v=1 id=1 d=f0", out_valid, out_id, out_data); end
    endtask

    // Entry state: out_valid=1, ptr=2.
    task automatic test_mid_reset();
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || out_id !== 2'd0 || out_data !== 8'h00) begin n_err++; $display("FAIL async_reset: got v=%b id=%0d d=%h expected v=0 id=0 d=00", out_valid, out_id, out_data); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL async_reset_ready: got %b expected 0000", req_ready); end
        step();
        req_valid = 4'b1001;
        req_data  = 32'h3C_00_00_C3;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL post_reset_grant: got %b expected 0001", req_ready); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_id !== 2'd0 || out_data !== 8'h3C) begin n_err++; $display("FAIL post_reset_result: got v=%b id=%0d d=%h expected v=1 id=0 d=3c", out_valid, out_id, out_data); end
        req_valid = 4'b1000;
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_id !== 2'd3 || out_data !== 8'hC3) begin n_err++; $display("FAIL post_reset_r3: got v=%b id=%0d d=%h expected v=1 id=3 d=c3", out_valid, out_id, out_data); end
        req_valid = 4'b0000;
        step();
    endtask

`ifdef NOT_GATE_ARB_GRANT_CNT_EN
    task automatic test_grant_cnt();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (grant_cnt !== 16'h0000) begin n_err++; $display("FAIL cnt_reset: got %h expected 0000", grant_cnt); end
        rst_n     = 1'b1;
        out_ready = 1'b1;
        req_valid = 4'b1111;
        for (int k = 0; k < 65537; k++) @(posedge clk);
        #1;
        req_valid = 4'b0000;
        n_cmp++; if (grant_cnt !== 16'h0001) begin n_err++; $display("FAIL cnt_wrap: got %h expected 0001", grant_cnt); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (grant_cnt !== 16'h0000) begin n_err++; $display("FAIL cnt_clear: got %h expected 0000", grant_cnt); end
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b0;
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_mid_reset();
`ifdef NOT_GATE_ARB_GRANT_CNT_EN
        test_grant_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/not_gate_rr_arbiter.md
Name: not_gate_rr_arbiter

Overview:
- Shares one WIDTH-bit bitwise inverter datapath among N_REQ requesters.
- Round-robin arbitration with per-requester valid/ready handshakes.
- Inverted result is registered in a single-entry output stage that carries the source ID and honours downstream backpressure.
- Sits between multiple client blocks and the shared inverter resource.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- WIDTH, 8, data width of each request and result
- ID_W, 2, width of out_id; must satisfy 2**ID_W >= N_REQ

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  N_REQ  per-requester request valid
- req_data  input  N_REQ*WIDTH  flattened request data; requester i occupies bits [i*WIDTH +: WIDTH]
- req_ready  output  N_REQ  per-requester accept; at most one bit set per cycle
- out_valid  output  1  result valid
- out_data  output  WIDTH  registered inverted data
- out_id  output  ID_W  index of the requester that produced the result
- out_ready  input  1  downstream accept

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-low (rst_n) and is released synchronously by the integrator.
- Reset values: out_valid=0, out_data=0, out_id=0, priority pointer ptr=0.
- req_ready is 0 while rst_n=0.
- Output stage capacity: can_accept = !out_valid | out_ready (combinational).
- Arbitration:
  - Combinational search from ptr upward, wrapping N_REQ-1 -> 0.
  - First i with req_valid[i]=1 wins and gets gnt[i].
- Handshake:
  - req_ready[i] = gnt[i] & can_accept.
  - A transfer occurs on a rising edge when req_valid[i] & req_ready[i].
  - req_ready never depends on req_data.
- On transfer:
  - out_data <= ~req_data[i]; out_id <= i; out_valid <= 1.
  - ptr <= i+1, wrapping to 0 after N_REQ-1.
- Output drain: out_valid & out_ready with no new transfer -> out_valid <= 0; out_data and out_id hold their last values.
- Simultaneous drain and transfer in the same cycle: the new result replaces the old one and out_valid stays 1 (full throughput, one result per cycle).
- Stall: out_valid=1 and out_ready=0 -> all req_ready=0. out_data, out_id and ptr hold.
- ptr changes only on a transfer. Idle cycles and stalled cycles leave ptr unchanged.
- Latency: 1 cycle from transfer edge to out_valid.
- Fairness: a continuously asserted requester waits at most N_REQ-1 transfers for another requester.
- Requester obligation: a requester must hold req_valid and req_data until accepted. The arbiter does not latch them.
- Reset mid-operation: any pending result is discarded asynchronously; out_valid=0 and ptr=0 immediately. No transfer occurs on the reset-release edge if rst_n is still low at that edge.
- Width rules: the inversion is bitwise on all WIDTH bits; no sign or arithmetic interpretation. out_id is zero-extended to ID_W.
- No combinational path from out_ready to out_data; a path from out_ready to req_ready is permitted.

Optional Feature:
- Macro: NOT_GATE_ARB_GRANT_CNT_EN
- Defined:
  - Adds output port grant_cnt, width 16, counting total transfers.
  - Increments by 1 on each transfer edge and wraps 0xFFFF -> 0x0000.
  - Reset value 0; cleared asynchronously by rst_n.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: rst_n=0 with req_valid=4'b1111 -> out_valid=0, out_data=0, out_id=0, req_ready=0. Release, out_ready=1 -> first grant to requester 0.
- Single requester: req_valid=4'b0100, req_data[2]=8'hA5, out_ready=1 -> req_ready=4'b0100; next cycle out_valid=1, out_data=8'h5A, out_id=2.
- Round-robin: all four valid continuously with data 8'h00, 8'h0F, 8'hF0, 8'hFF; out_ready=1 -> out_id sequence 0,1,2,3,0; out_data sequence 8'hFF, 8'hF0, 8'h0F, 8'h00, 8'hFF; one result per cycle.
- Backpressure: out_ready=0 for 3 cycles with a result held -> out_valid, out_data, out_id stable, req_ready=0, ptr unchanged. out_ready=1 -> drain and a new transfer in the same cycle, out_valid remains 1.
- Mid-operation reset: assert rst_n=0 while out_valid=1 and ptr=2 -> out_valid drops without a clock edge. After release, requester 0 wins over requester 3.
- NOT_GATE_ARB_GRANT_CNT_EN defined: 65537 transfers -> grant_cnt=1 (wrap). Reset -> grant_cnt=0.
